// File: rtl/crc_pkg.sv
//==============================================================================
// Module   : crc_pkg
// Brief    : Shared constants and the bit-serial step for the 10-bit message
//            CRC, G(y) = 1 + y + y^8 + y^9.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package crc_pkg;

    localparam int MSG_W = 10;
    localparam int CRC_W = 9;
    localparam logic [CRC_W-1:0] POLY = 9'h103;

    // One LFSR step consuming message bit b, highest-order coefficient first.
    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] r,
                                                   input logic             b);
        logic fb;
        fb = r[CRC_W-1] ^ b;
        return {r[CRC_W-2:0], 1'b0} ^ (fb ? POLY : {CRC_W{1'b0}});
    endfunction

endpackage

`default_nettype wire

// File: rtl/crc_stage.sv
//==============================================================================
// Module   : crc_stage
// Brief    : One pipeline level: NBITS serial CRC steps followed by a register
//            holding the partial remainder and the still-unconsumed bits.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module crc_stage
    import crc_pkg::*;
#(
    parameter int NBITS = 3,
    parameter int IN_W  = 10,
    parameter int OUT_W = (IN_W > NBITS) ? (IN_W - NBITS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CRC_W-1:0] i_rem,
    input  logic [IN_W-1:0]  i_msg,
    output logic [CRC_W-1:0] o_rem,
    output logic [OUT_W-1:0] o_msg
);

    logic [CRC_W-1:0] w_rem;
    logic [CRC_W-1:0] r_rem;

    always_comb begin
        w_rem = i_rem;
        for (int i = 0; i < NBITS; i++) begin
            w_rem = crc_step(w_rem, i_msg[IN_W-1-i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rem <= '0;
        end else begin
            r_rem <= w_rem;
        end
    end

    assign o_rem = r_rem;

    // The last level has nothing left to forward, so it carries no message register.
    generate
        if (IN_W > NBITS) begin : g_carry
            logic [OUT_W-1:0] r_msg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_msg <= '0;
                end else begin
                    r_msg <= i_msg[OUT_W-1:0];
                end
            end

            assign o_msg = r_msg;
        end else begin : g_no_carry
            assign o_msg = '0;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/crc_4_level_pipeline.sv
//==============================================================================
// Module   : crc_4_level_pipeline
// Brief    : 9-bit CRC remainder of a 10-bit message, one message per clock,
//            unrolled over four register levels (3,3,2,2 bits per level).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module crc_4_level_pipeline
    import crc_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [MSG_W-1:0] data_in,
    output logic [CRC_W-1:0] data_out
);

    localparam int c_left1_w = MSG_W - 3;
    localparam int c_left2_w = c_left1_w - 3;
    localparam int c_left3_w = c_left2_w - 2;

    logic [CRC_W-1:0]     w_rem1, w_rem2, w_rem3, w_rem4;
    logic [c_left1_w-1:0] w_msg1;
    logic [c_left2_w-1:0] w_msg2;
    logic [c_left3_w-1:0] w_msg3;
    logic                 w_unused_msg4;

    // Every message starts from a zero remainder.
    crc_stage #(.NBITS(3), .IN_W(MSG_W)) u_level1 (
        .clk   (clk),
        .reset (reset),
        .i_rem ({CRC_W{1'b0}}),
        .i_msg (data_in),
        .o_rem (w_rem1),
        .o_msg (w_msg1)
    );

    crc_stage #(.NBITS(3), .IN_W(c_left1_w)) u_level2 (
        .clk   (clk),
        .reset (reset),
        .i_rem (w_rem1),
        .i_msg (w_msg1),
        .o_rem (w_rem2),
        .o_msg (w_msg2)
    );

    crc_stage #(.NBITS(2), .IN_W(c_left2_w)) u_level3 (
        .clk   (clk),
        .reset (reset),
        .i_rem (w_rem2),
        .i_msg (w_msg2),
        .o_rem (w_rem3),
        .o_msg (w_msg3)
    );

    crc_stage #(.NBITS(2), .IN_W(c_left3_w)) u_level4 (
        .clk   (clk),
        .reset (reset),
        .i_rem (w_rem3),
        .i_msg (w_msg3),
        .o_rem (w_rem4),
        .o_msg (w_unused_msg4)
    );

    assign data_out = w_rem4;

endmodule

`default_nettype wire

// File: tb/tb_crc_4_level_pipeline.sv
//==============================================================================
// Module   : tb_crc_4_level_pipeline
// Brief    : Self-checking bench: directed vectors plus a random scoreboard
//            against a polynomial long-division reference.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_crc_4_level_pipeline;

    logic       clk;
    logic       reset;
    logic [9:0] data_in;
    logic [8:0] data_out;

    int n_checks;
    int n_fail;

    logic [8:0] exp_q[$];

    crc_4_level_pipeline dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // M(y)*y^9 mod G(y) by plain long division, G = y^9 + y^8 + y + 1.
    function automatic logic [8:0] ref_crc(input logic [9:0] m);
        logic [18:0] v;
        logic [18:0] g;
        v = {m, 9'b0};
        g = 19'h00303;
        for (int i = 18; i >= 9; i--) begin
            if (v[i]) v = v ^ (g << (i - 9));
        end
        return v[8:0];
    endfunction

    task automatic check_eq(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 9'h%03h, expected 9'h%03h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply one message for one clock and compare against the result due now.
    task automatic drive_model(input logic [9:0] m, input string tag);
        data_in = m;
        exp_q.push_back(ref_crc(m));
        tick();
        check_eq(tag, data_out, exp_q.pop_front());
    endtask

    task automatic hold_check(input logic [9:0] m, input logic [8:0] exp, input string tag);
        data_in = m;
        repeat (4) tick();
        check_eq(tag, data_out, exp);
    endtask

    logic [9:0] vec[4];
    logic [8:0] vexp[4];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        data_in  = 10'h3FF;

        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("reset_hold", data_out, 9'h000);
        end

        reset   = 1'b0;
        data_in = 10'b1100000011;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("poly_g", data_out, 9'h000);
        end

        hold_check(10'b0000000001, 9'h103, "vec_001");
        hold_check(10'b0000000010, 9'h105, "vec_002");
        hold_check(10'b0000000011, 9'h006, "vec_003");
        hold_check(10'b1000000000, 9'h004, "vec_200");

        vec[0] = 10'h001; vexp[0] = 9'h103;
        vec[1] = 10'h002; vexp[1] = 9'h105;
        vec[2] = 10'h003; vexp[2] = 9'h006;
        vec[3] = 10'h200; vexp[3] = 9'h004;
        for (int t = 0; t < 7; t++) begin
            data_in = (t < 4) ? vec[t] : vec[3];
            tick();
            if (t >= 3) check_eq("stream", data_out, vexp[t-3]);
        end

        // The pipeline now holds 10'h200 everywhere, so the next three results are its CRC.
        exp_q.delete();
        repeat (3) exp_q.push_back(ref_crc(10'h200));
        for (int i = 0; i < 20; i++) drive_model(10'($urandom), "rand_pre");

        reset   = 1'b1;
        data_in = 10'($urandom);
        tick();
        check_eq("mid_reset", data_out, 9'h000);
        reset = 1'b0;

        // In-flight work is discarded: the first three post-reset edges yield zero.
        exp_q.delete();
        repeat (3) exp_q.push_back(9'h000);
        for (int i = 0; i < 200; i++) drive_model(10'($urandom), "rand_post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
